// File: rtl/stack_unit_if.sv
// stack_unit_if
// Request/response bundle between the control unit and the stack unit.
//   push, pop, push_data  : request side, driven by the control unit (master)
//   pop_out               : last popped word
//   push_done, pop_done   : one-cycle completion pulses
//   sp, full, empty       : occupancy status
//   stack_err             : one-cycle overflow/underflow pulse
//   top_data              : peek at the top entry (only with STACK_PEEK_EN)
// Optional feature macro: STACK_PEEK_EN
interface stack_unit_if #(
    parameter int DATA_W = 16,
    parameter int PTR_W  = 7
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] pop_out;
    logic              push_done;
    logic              pop_done;
    logic [PTR_W-1:0]  sp;
    logic              full;
    logic              empty;
    logic              stack_err;
`ifdef STACK_PEEK_EN
    logic [DATA_W-1:0] top_data;

    modport master (
        output push, pop, push_data,
        input  pop_out, push_done, pop_done, sp, full, empty, stack_err, top_data
    );

    modport slave (
        input  push, pop, push_data,
        output pop_out, push_done, pop_done, sp, full, empty, stack_err, top_data
    );
`else
    modport master (
        output push, pop, push_data,
        input  pop_out, push_done, pop_done, sp, full, empty, stack_err
    );

    modport slave (
        input  push, pop, push_data,
        output pop_out, push_done, pop_done, sp, full, empty, stack_err
    );
`endif
endinterface

// File: rtl/stack_unit.sv
// stack_unit
// Hardware LIFO stack serving push/pop requests from the control unit
// (CALL/RET, PUSH/POP, link-register spills). A request is accepted in IDLE,
// executed on the following edge, and acknowledged with a one-cycle done pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : stack_unit_if.slave (push, pop, push_data, pop_out, push_done,
//          pop_done, sp, full, empty, stack_err, and top_data when enabled)
// Optional feature macro: STACK_PEEK_EN adds a combinational peek at the top
// entry on bus.top_data (0 when empty).
module stack_unit #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int PTR_W  = 7
) (
    input  logic          clk,
    input  logic          rst,
    stack_unit_if.slave   bus
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DO_PUSH = 2'd1,
        DO_POP  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] pop_out_reg;
    logic [PTR_W-1:0]  sp_reg;
    logic [PTR_W-1:0]  sp_inc;
    logic [PTR_W-1:0]  sp_dec;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              push_done_reg;
    logic              pop_done_reg;
    logic              err_reg;
    logic              is_full;
    logic              is_empty;

    // Occupancy decode; the write slot is sp itself and the top entry is
    // sp-1, so the read address is only meaningful while not empty.
    assign is_full  = (sp_reg == PTR_W'(DEPTH));
    assign is_empty = (sp_reg == '0);
    assign sp_inc   = sp_reg + PTR_W'(1);
    assign sp_dec   = sp_reg - PTR_W'(1);
    assign wr_addr  = sp_reg[ADDR_W-1:0];
    assign rd_addr  = sp_dec[ADDR_W-1:0];

    // Next-state logic: push wins over a simultaneous pop, and every
    // execute state lasts exactly one cycle, so requests arriving while
    // busy are simply not looked at.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.push) begin
                    next_state = DO_PUSH;
                end else if (bus.pop) begin
                    next_state = DO_POP;
                end
            end
            DO_PUSH: next_state = IDLE;
            DO_POP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the push word together with the request so the control unit
    // is free to change push_data during the execute cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else if (state == IDLE && bus.push) begin
            data_reg <= bus.push_data;
        end
    end

    // Execute the captured operation: update the pointer and pop result,
    // and raise the done/error pulses that self-clear on the next edge.
    // Saturation at both ends leaves sp and the stored entries untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg        <= '0;
            pop_out_reg   <= '0;
            push_done_reg <= 1'b0;
            pop_done_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            push_done_reg <= 1'b0;
            pop_done_reg  <= 1'b0;
            err_reg       <= 1'b0;
            case (state)
                DO_PUSH: begin
                    push_done_reg <= 1'b1;
                    if (!is_full) begin
                        sp_reg <= sp_inc;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
                DO_POP: begin
                    pop_done_reg <= 1'b1;
                    if (!is_empty) begin
                        pop_out_reg <= mem[rd_addr];
                        sp_reg      <= sp_dec;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage array is deliberately not reset; a write only happens from
    // DO_PUSH, which an asynchronous reset leaves before the write edge.
    always_ff @(posedge clk) begin
        if (state == DO_PUSH && !is_full) begin
            mem[wr_addr] <= data_reg;
        end
    end

    assign bus.pop_out   = pop_out_reg;
    assign bus.push_done = push_done_reg;
    assign bus.pop_done  = pop_done_reg;
    assign bus.stack_err = err_reg;
    assign bus.sp        = sp_reg;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;

`ifdef STACK_PEEK_EN
    // Combinational peek at the current top entry, zero when empty.
    assign bus.top_data = is_empty ? '0 : mem[rd_addr];
`endif

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit
// Self-checking bench for stack_unit: directed scenarios followed by random
// push/pop traffic, all compared against a queue-based LIFO model.
// Optional feature macro: STACK_PEEK_EN (also checks top_data when defined).
module tb_stack_unit;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int PTR_W  = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    stack_unit_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

    stack_unit #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // LIFO reference: a queue whose back is the top of stack.
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] model_pop_out = '0;
    logic              exp_push_done = 1'b0;
    logic              exp_pop_done  = 1'b0;
    logic              exp_err       = 1'b0;

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare every visible output against the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, "/push_done"}, 32'(bus.push_done), 32'(exp_push_done));
        checkOutput({tag, "/pop_done"},  32'(bus.pop_done),  32'(exp_pop_done));
        checkOutput({tag, "/stack_err"}, 32'(bus.stack_err), 32'(exp_err));
        checkOutput({tag, "/sp"},        32'(bus.sp),        32'(model_q.size()));
        checkOutput({tag, "/full"},      32'(bus.full),      32'(model_q.size() == DEPTH));
        checkOutput({tag, "/empty"},     32'(bus.empty),     32'(model_q.size() == 0));
        checkOutput({tag, "/pop_out"},   32'(bus.pop_out),   32'(model_pop_out));
`ifdef STACK_PEEK_EN
        checkOutput({tag, "/top_data"},  32'(bus.top_data),
                    (model_q.size() == 0) ? 32'd0 : 32'(model_q[$]));
`endif
    endtask

    // While an operation executes, no pulse may be visible yet.
    task automatic checkBusy(input string tag);
        checkOutput({tag, "/busy_push_done"}, 32'(bus.push_done), 32'd0);
        checkOutput({tag, "/busy_pop_done"},  32'(bus.pop_done),  32'd0);
        checkOutput({tag, "/busy_err"},       32'(bus.stack_err), 32'd0);
    endtask

    // Reference behaviour of one accepted request.
    task automatic modelOp(input logic p, input logic q, input logic [DATA_W-1:0] d);
        exp_push_done = 1'b0;
        exp_pop_done  = 1'b0;
        exp_err       = 1'b0;
        if (p) begin
            exp_push_done = 1'b1;
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else exp_err = 1'b1;
        end else if (q) begin
            exp_pop_done = 1'b1;
            if (model_q.size() > 0) model_pop_out = model_q.pop_back();
            else exp_err = 1'b1;
        end
    endtask

    // One-cycle request, then check the busy cycle and the done cycle.
    task automatic applyStimulus(input logic p, input logic q, input logic [DATA_W-1:0] d,
                                 input string tag);
        @(negedge clk);
        bus.push      = p;
        bus.pop       = q;
        bus.push_data = d;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        checkBusy(tag);
        modelOp(p, q, d);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_data = '0;

        // Asynchronous reset before the first clock edge.
        #2 rst = 1'b1;
        #2;
        checkAll("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // LIFO ordering.
        $display("[TB] push/pop order");
        applyStimulus(1'b1, 1'b0, 16'h1111, "order_push");
        applyStimulus(1'b1, 1'b0, 16'h2222, "order_push");
        applyStimulus(1'b1, 1'b0, 16'h3333, "order_push");
        applyStimulus(1'b0, 1'b1, 16'h0000, "order_pop");
        applyStimulus(1'b0, 1'b1, 16'h0000, "order_pop");
        applyStimulus(1'b0, 1'b1, 16'h0000, "order_pop");

        // Underflow keeps the previous pop result.
        $display("[TB] underflow");
        applyStimulus(1'b0, 1'b1, 16'h0000, "underflow");

        // Idle cycle with no request must not pulse anything.
        applyStimulus(1'b0, 1'b0, 16'h5A5A, "no_request");

        // Simultaneous push/pop, then a pop held through the busy cycle.
        $display("[TB] simultaneous and busy");
        @(negedge clk);
        bus.push      = 1'b1;
        bus.pop       = 1'b1;
        bus.push_data = 16'h00AA;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        checkBusy("simul");
        modelOp(1'b1, 1'b1, 16'h00AA);
        @(posedge clk);
        #1;
        checkAll("simul");
        @(posedge clk);
        #1;
        bus.pop = 1'b0;
        checkBusy("held_pop");
        modelOp(1'b0, 1'b1, 16'h0000);
        @(posedge clk);
        #1;
        checkAll("held_pop");

        // Fill to capacity, then overflow.
        $display("[TB] overflow");
        while (model_q.size() < DEPTH) begin
            applyStimulus(1'b1, 1'b0, 16'(model_q.size()), "fill");
        end
        applyStimulus(1'b1, 1'b0, 16'hBEEF, "overflow");
        applyStimulus(1'b0, 1'b1, 16'h0000, "after_overflow_pop");

        // Random traffic against the model.
        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            logic p;
            logic q;
            p = ($urandom_range(0, 99) < 45);
            q = ($urandom_range(0, 99) < 55);
            applyStimulus(p, q, 16'($urandom), "random");
        end

        // Reset in the middle of a push, with at least three entries stored.
        $display("[TB] reset mid-operation");
        while (model_q.size() < 3) begin
            applyStimulus(1'b1, 1'b0, 16'($urandom), "prefill");
        end
        applyStimulus(1'b1, 1'b0, 16'h4444, "pre_reset_push");
        applyStimulus(1'b0, 1'b1, 16'h0000, "pre_reset_pop");
        @(negedge clk);
        bus.push      = 1'b1;
        bus.push_data = 16'h5555;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        bus.push = 1'b0;
        model_q.delete();
        model_pop_out = '0;
        exp_push_done = 1'b0;
        exp_pop_done  = 1'b0;
        exp_err       = 1'b0;
        checkAll("async_reset");
        @(posedge clk);
        #1;
        checkAll("reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkAll("reset_released");

        applyStimulus(1'b1, 1'b0, 16'h6666, "post_reset_push");
        applyStimulus(1'b0, 1'b1, 16'h0000, "post_reset_pop");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
